// File: rtl/cell_sweep_checker.sv
// Exhaustive sweep engine for an N-input combinational cell, checked against a truth table.
// Latency: vector k held SETTLE cycles; its observation appears one cycle after its sampling edge.
// No backpressure: observations stream as one-cycle pulses; start is ignored while busy.
module cell_sweep_checker #(
    parameter int N_IN = 4,
    parameter int SETTLE = 2,
    parameter logic [(2**N_IN)-1:0] EXPECT = 16'h0777
) (
    input  logic            CK,
    input  logic            RN,
    input  logic            start,
    input  logic            abort,
    input  logic            gray_mode,
    output logic [N_IN-1:0] stim,
    input  logic            dut_zn,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic            first_err_valid,
    output logic [N_IN-1:0] first_err_idx,
    output logic            obs_valid,
    output logic [N_IN-1:0] obs_stim,
    output logic            obs_zn,
    output logic            obs_exp
);
    localparam int NV = 2 ** N_IN;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [N_IN-1:0] k;
    logic [SW-1:0]   settle_cnt;
    logic            gray_q;
    logic            accept;
    logic            sample;
    logic            last;
    logic [N_IN-1:0] vec;
    logic            exp_bit;
    logic            mismatch;

    assign vec      = gray_q ? (k ^ (k >> 1)) : k;
    assign exp_bit  = EXPECT[vec];
    // X or Z on the cell output must count as a failure, hence the 4-state compare.
    assign mismatch = (dut_zn !== exp_bit);
    assign sample   = (state == RUN) && !abort && (settle_cnt == SW'(SETTLE - 1));
    assign last     = (k == N_IN'(NV - 1));

    assign stim = (state == RUN) ? vec : '0;
    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (err_cnt == '0);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start && !abort) begin
                    state_nxt = RUN;
                    accept    = 1'b1;
                end
            end
            RUN: begin
                if (abort)
                    state_nxt = IDLE;
                else if (sample && last)
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            k               <= '0;
            settle_cnt      <= '0;
            gray_q          <= 1'b0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            obs_valid       <= 1'b0;
            obs_stim        <= '0;
            obs_zn          <= 1'b0;
            obs_exp         <= 1'b0;
        end else begin
            obs_valid <= 1'b0;
            if (accept) begin
                k               <= '0;
                settle_cnt      <= '0;
                gray_q          <= gray_mode;
                err_cnt         <= '0;
                first_err_valid <= 1'b0;
                first_err_idx   <= '0;
            end else if (state == RUN && abort) begin
                // Results are left in place for inspection; the pending sample is dropped.
                k          <= '0;
                settle_cnt <= '0;
            end else if (state == RUN) begin
                if (sample) begin
                    settle_cnt <= '0;
                    k          <= k + N_IN'(1);
                    obs_valid  <= 1'b1;
                    obs_stim   <= vec;
                    obs_zn     <= dut_zn;
                    obs_exp    <= exp_bit;
                    if (mismatch) begin
                        if (err_cnt != (N_IN + 1)'(NV))
                            err_cnt <= err_cnt + (N_IN + 1)'(1);
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_idx   <= vec;
                        end
                    end
                end else begin
                    settle_cnt <= settle_cnt + SW'(1);
                end
            end
        end
    end
endmodule
